mem_access_unit: RTL

Parametrised load/store access unit between the execute and writeback stages of the CPU pipeline. It accepts one memory request at a time over a valid/ready handshake and decodes the region from the top address bits. It drives registered per-region byte write masks, read enables and lane-shifted store data. It then waits a per-region latency, captures the region's read data, and returns a lane-aligned, sign- or zero-extended load result with a response pulse. Misaligned requests are rejected with an error response and touch no region.

---
 rtl/mem_access_unit_pkg.sv | 28 ++
 rtl/mem_access_unit_load_align.sv | 38 +++
 rtl/mem_access_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store access unit: size encodings,
// controller states and the size-to-byte-count helper.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    logic [3:0] nbytes;
    case (size)
      SZ_BYTE: nbytes = 4'd1;
      SZ_HALF: nbytes = 4'd2;
      SZ_WORD: nbytes = 4'd4;
      default: nbytes = 4'd8;
    endcase
    return nbytes;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Combinational load aligner: moves the addressed bytes down to lane 0 and
// sign- or zero-extends them to the full bus width.
module load_align
  import mem_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  localparam int BYTES      = DATA_WIDTH / 8,
  localparam int LANE_W     = $clog2(BYTES)
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [LANE_W-1:0]     lane,
  input  logic [1:0]            size,
  input  logic                  is_signed,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] shifted;
  logic [3:0]            nbytes;
  logic                  sign_bit;
  logic                  ext;

  always_comb begin
    shifted  = word >> {lane, 3'b000};
    nbytes   = size_bytes(size);
    sign_bit = 1'b0;
    data     = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (b == int'(nbytes) - 1) sign_bit = shifted[8*b+7];
    end
    // full-width loads have no bits left to extend into
    ext = is_signed && (int'(nbytes) < BYTES) && sign_bit;
    for (int b = 0; b < BYTES; b++) begin
      if (b < int'(nbytes)) data[8*b +: 8] = shifted[8*b +: 8];
      else                  data[8*b +: 8] = {8{ext}};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: decodes the region from the top address
// bits, drives registered per-region strobes, waits out the region latency
// and returns an aligned load result with a one-cycle response pulse.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter  int                     ADDR_WIDTH  = 32,
  parameter  int                     DATA_WIDTH  = 32,
  parameter  int                     NUM_REGIONS = 4,
  parameter  logic [NUM_REGIONS-1:0] SLOW_MASK   = 4'b1000,
  parameter  int                     IO_WAIT     = 3,
  localparam int                     BYTES       = DATA_WIDTH / 8,
  localparam int                     LANE_W      = $clog2(BYTES),
  localparam int                     RSEL_W      = $clog2(NUM_REGIONS)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               ReqValid,
  output logic                               ReqReady,
  input  logic [ADDR_WIDTH-1:0]              Address,
  input  logic [DATA_WIDTH-1:0]              WriteData,
  input  logic                               WriteEnable,
  input  logic [1:0]                         MemSize,
  input  logic                               LoadSigned,
  output logic [ADDR_WIDTH-LANE_W-1:0]       MemAddr,
  output logic [NUM_REGIONS*BYTES-1:0]       RegionWriteMask,
  output logic [NUM_REGIONS-1:0]             RegionReadEn,
  output logic [DATA_WIDTH-1:0]              ShiftedData,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0]  ReadData,
  output logic                               RespValid,
  output logic [DATA_WIDTH-1:0]              LoadData,
  output logic                               Misaligned
);

  localparam int CNT_W = (IO_WAIT > 0) ? $clog2(IO_WAIT + 1) : 1;

  state_t state, next_state;

  logic [CNT_W-1:0]  cnt;
  logic [RSEL_W-1:0] lat_region;
  logic [LANE_W-1:0] lat_lane;
  logic [1:0]        lat_size;
  logic              lat_signed;
  logic              lat_write;

  logic                         accept;
  logic [RSEL_W-1:0]            req_region;
  logic [LANE_W-1:0]            req_lane;
  logic [3:0]                   req_nbytes;
  logic                         req_legal;
  logic [BYTES-1:0]             req_mask;
  logic [NUM_REGIONS*BYTES-1:0] req_wmask;
  logic [NUM_REGIONS-1:0]       req_ren;
  logic [DATA_WIDTH-1:0]        cap_word;
  logic [DATA_WIDTH-1:0]        aligned;

  assign ReqReady = (state == ST_IDLE);
  assign accept   = ReqValid && ReqReady;

  always_comb begin
    req_region = Address[ADDR_WIDTH-1 -: RSEL_W];
    req_lane   = Address[LANE_W-1:0];
    req_nbytes = size_bytes(MemSize);
    req_legal  = ((req_lane & LANE_W'(req_nbytes - 4'd1)) == '0) &&
                 !((MemSize == SZ_DWORD) && (DATA_WIDTH == 32));
    req_mask   = BYTES'(((16'd1 << req_nbytes) - 16'd1) << req_lane);
    req_wmask  = '0;
    for (int r = 0; r < NUM_REGIONS; r++) begin
      if (RSEL_W'(r) == req_region) req_wmask[r*BYTES +: BYTES] = req_mask;
    end
    req_ren             = '0;
    req_ren[req_region] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (accept) next_state = req_legal ? ST_ACCESS : ST_RESP;
      ST_ACCESS: next_state = ST_WAIT;
      ST_WAIT:   if (cnt == '0) next_state = ST_RESP;
      ST_RESP:   next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  assign cap_word = ReadData[lat_region*DATA_WIDTH +: DATA_WIDTH];

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .word      (cap_word),
    .lane      (lat_lane),
    .size      (lat_size),
    .is_signed (lat_signed),
    .data      (aligned)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt             <= '0;
      lat_region      <= '0;
      lat_lane        <= '0;
      lat_size        <= SZ_BYTE;
      lat_signed      <= 1'b0;
      lat_write       <= 1'b0;
      MemAddr         <= '0;
      RegionWriteMask <= '0;
      RegionReadEn    <= '0;
      ShiftedData     <= '0;
      RespValid       <= 1'b0;
      LoadData        <= '0;
      Misaligned      <= 1'b0;
    end else begin
      // strobes and the response are single-cycle pulses by default
      RegionWriteMask <= '0;
      RegionReadEn    <= '0;
      RespValid       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lat_region <= req_region;
            lat_lane   <= req_lane;
            lat_size   <= MemSize;
            lat_signed <= LoadSigned;
            lat_write  <= WriteEnable;
            if (req_legal) begin
              MemAddr     <= Address[ADDR_WIDTH-1:LANE_W];
              ShiftedData <= WriteData << {req_lane, 3'b000};
              if (WriteEnable) RegionWriteMask <= req_wmask;
              else             RegionReadEn    <= req_ren;
            end else begin
              RespValid  <= 1'b1;
              Misaligned <= 1'b1;
              LoadData   <= '0;
            end
          end
        end
        ST_ACCESS: cnt <= SLOW_MASK[lat_region] ? CNT_W'(IO_WAIT) : '0;
        ST_WAIT: begin
          if (cnt == '0) begin
            RespValid  <= 1'b1;
            Misaligned <= 1'b0;
            LoadData   <= lat_write ? '0 : aligned;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          LoadData   <= '0;
          Misaligned <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
